// File: rtl/selen_wb_pkg.sv
// Shared types for the selen Wishbone master: FSM states, termination priority, retry width.
// Core bus widths default here unless the including build already defines them.
`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

package selen_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TERM_NONE = 2'd0,
    TERM_ERR  = 2'd1,
    TERM_ACK  = 2'd2,
    TERM_RTY  = 2'd3
  } term_e;

  localparam int RETRY_W = 4;

  // err wins over ack, ack over rty; nothing counts while stb is low
  function automatic term_e decode_term(input logic stb, input logic err,
                                        input logic ack, input logic rty);
    term_e t;
    t = TERM_NONE;
    if (stb) begin
      if (err)      t = TERM_ERR;
      else if (ack) t = TERM_ACK;
      else if (rty) t = TERM_RTY;
    end
    return t;
  endfunction

endpackage

// File: rtl/selen_wb_watchdog.sv
// Bus-cycle timeout counter: counts while enabled, clears on clr_i, flags the last allowed cycle.
module selen_wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // count 0 is the first strobe cycle, so strobe stays up exactly TIMEOUT_CYCLES cycles
  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/selen_wb_master.sv
// Wishbone B4 classic master: one outstanding load/store, err>ack>rty, bounded retry.
// Optional bus timeout under SELEN_WB_MASTER_TIMEOUT_EN.
module selen_wb_master
  import selen_wb_pkg::*;
#(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_val,
  output logic                        req_rdy,
  input  logic [`CORE_ADDR_WIDTH-1:0] req_addr,
  input  logic                        req_we,
  input  logic [`CORE_BE_WIDTH-1:0]   req_be,
  input  logic [`CORE_DATA_WIDTH-1:0] req_wdata,
  output logic                        resp_val,
  output logic                        resp_err,
  output logic [`CORE_DATA_WIDTH-1:0] resp_rdata,
  output logic [`CORE_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [`CORE_DATA_WIDTH-1:0] wb_dat_o,
  output logic [`CORE_BE_WIDTH-1:0]   wb_sel_o,
  output logic                        wb_we_o,
  output logic                        wb_cyc_o,
  output logic                        wb_stb_o,
  input  logic [`CORE_DATA_WIDTH-1:0] wb_dat_i,
  input  logic                        wb_ack_i,
  input  logic                        wb_err_i,
  input  logic                        wb_rty_i
);

  state_e                      state_q, state_d;
  logic [RETRY_W-1:0]          retry_q, retry_d;
  logic [`CORE_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [`CORE_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [`CORE_BE_WIDTH-1:0]   sel_q, sel_d;
  logic                        we_q, we_d;
  logic                        cyc_q, cyc_d;
  logic                        rval_q, rval_d;
  logic                        rerr_q, rerr_d;
  logic [`CORE_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                        tmo_expire;
  logic                        fail;
  term_e                       term;

`ifdef SELEN_WB_MASTER_TIMEOUT_EN
  selen_wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != ST_BUS),
    .en_i     (state_q == ST_BUS),
    .expire_o (tmo_expire)
  );
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    rval_d  = 1'b0;
    rerr_d  = 1'b0;
    rdata_d = '0;
    fail    = 1'b0;
    term    = decode_term(cyc_q, wb_err_i, wb_ack_i, wb_rty_i);
    case (state_q)
      ST_IDLE: if (req_val) begin
        adr_d   = req_addr;
        we_d    = req_we;
        sel_d   = req_be;
        dat_d   = req_we ? req_wdata : '0;
        cyc_d   = 1'b1;
        state_d = ST_BUS;
      end
      ST_BUS: case (term)
        TERM_ERR: fail = 1'b1;
        TERM_ACK: begin
          cyc_d   = 1'b0;
          rval_d  = 1'b1;
          rdata_d = we_q ? '0 : wb_dat_i;
          state_d = ST_RESP;
        end
        TERM_RTY: if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          cyc_d   = 1'b0;
          state_d = ST_BACKOFF;
        end else begin
          fail = 1'b1;
        end
        default: fail = tmo_expire;
      endcase
      ST_BACKOFF: begin
        cyc_d   = 1'b1;
        state_d = ST_BUS;
      end
      default: begin
        retry_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    // bus error, retry exhaustion and timeout all end the same way
    if (fail) begin
      cyc_d   = 1'b0;
      rval_d  = 1'b1;
      rerr_d  = 1'b1;
      state_d = ST_RESP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rval_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      rval_q  <= rval_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_rdy    = (state_q == ST_IDLE);
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign resp_val   = rval_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = rdata_q;

endmodule
